// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the RV32E multi-cycle NPC core.
// Holds the architectural PC and issues one instruction-memory read per
// instruction. It hands the fetched word and its PC to decode, then waits
// for commit to return the next PC. At most one instruction is in flight.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   req_valid/ready/addr  instruction-memory read request (addr = pc)
//   rsp_valid/ready/data  instruction-memory response
//   rsp_err               bus error on the response
//   out_valid/ready       instruction handoff to decode
//   out_inst/pc/fault     fetched word, its PC, fetch fault flag
//   npc_valid, npc        next PC from commit
//   fetch_cnt             instructions handed to decode (wrapping)
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    REQ,
    WAIT_RSP,
    HOLD,
    WAIT_NPC
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic        fault_q;
  logic [31:0] cnt_q;
  logic        misaligned;

  assign misaligned = (pc[1:0] != 2'b00);

  // Handshake outputs decode state only; they are additionally held low
  // while rst is asserted so nothing is offered during reset.
  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      REQ: begin
        req_valid = rst & ~misaligned;
        if (misaligned)     state_nxt = HOLD;
        else if (req_ready) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        rsp_ready = rst;
        if (rsp_valid) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = rst;
        if (out_ready) state_nxt = WAIT_NPC;
      end
      WAIT_NPC: begin
        if (npc_valid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= REQ;
      pc      <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == REQ && misaligned) begin
        inst_q  <= '0;
        fault_q <= 1'b1;
      end
      if (state == WAIT_RSP && rsp_valid) begin
        inst_q  <= rsp_err ? '0 : rsp_data;
        fault_q <= rsp_err;
      end
      if (state == HOLD && out_ready) cnt_q <= cnt_q + 32'd1;
      if (state == WAIT_NPC && npc_valid) pc <= npc;
    end
  end

  assign req_addr  = pc;
  assign out_pc    = pc;
  assign out_inst  = inst_q;
  assign out_fault = fault_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: self-checking bench for ifu_fetch.
// Part 1 applies a cycle table of inputs and expected outputs (basic fetch,
// backpressure, bus error, misaligned redirect, stray npc pulses, reset in
// WAIT_RSP and HOLD). Part 2 drives random memory/decode/commit behaviour
// and checks against a per-instruction transaction model.
module tb_ifu_fetch;

  localparam logic [31:0] RP = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_fault(out_fault),
    .npc_valid(npc_valid), .npc(npc), .fetch_cnt(fetch_cnt)
  );

  typedef struct {
    logic        rst, rqr, rsv;
    logic [31:0] rsd;
    logic        rse, ordy, nv;
    logic [31:0] n;
    logic        erqv, ersr, eov;
    logic [31:0] einst, epc;
    logic        eflt;
    logic [31:0] ecnt;
    logic        co;   // also check out_inst/out_fault on this row
  } vec_t;

  vec_t vt[$];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // random-phase model state
  logic [31:0] m_pc, m_cnt, mem_addr, npc_nxt, e_inst;
  logic        m_req_done, mem_busy, mem_err, cur_err, npc_pending, npc_drive, e_flt;
  int unsigned mem_wait, npc_wait, idle, n_insts;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t V(
    input logic rst_i, input logic rqr, input logic rsv, input logic [31:0] rsd,
    input logic rse, input logic ordy, input logic nv, input logic [31:0] n,
    input logic erqv, input logic ersr, input logic eov, input logic [31:0] einst,
    input logic [31:0] epc, input logic eflt, input logic [31:0] ecnt, input logic co);
    vec_t r;
    r.rst = rst_i; r.rqr = rqr; r.rsv = rsv; r.rsd = rsd; r.rse = rse;
    r.ordy = ordy; r.nv = nv; r.n = n;
    r.erqv = erqv; r.ersr = ersr; r.eov = eov; r.einst = einst; r.epc = epc;
    r.eflt = eflt; r.ecnt = ecnt; r.co = co;
    return r;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //     rst rqr rsv rsd           rse ordy nv n            | rqv rsr ov inst          pc        flt cnt co
    vt.push_back(V(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        RP,       0, 0, 1)); // r0 reset
    vt.push_back(V(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        RP,       0, 0, 1)); // r1 REQ
    vt.push_back(V(1, 0, 1, 32'h413,      0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        RP,       0, 0, 0)); // r2 WAIT_RSP
    vt.push_back(V(1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 1, 32'h413,      RP,       0, 0, 1)); // r3 HOLD
    vt.push_back(V(1, 0, 0, 32'h0,        0, 0, 1, RP+4,         0, 0, 0, 32'h0,        RP,       0, 1, 0)); // r4 WAIT_NPC
    vt.push_back(V(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        RP+4,     0, 1, 0)); // r5 REQ stalled
    vt.push_back(V(1, 0, 0, 32'h0,        0, 0, 1, 32'h1234_5670,1, 0, 0, 32'h0,        RP+4,     0, 1, 0)); // r6 stray npc
    vt.push_back(V(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        RP+4,     0, 1, 0)); // r7
    vt.push_back(V(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        RP+4,     0, 1, 0)); // r8 accepted
    vt.push_back(V(1, 0, 0, 32'h0,        0, 0, 1, 32'h100,      0, 1, 0, 32'h0,        RP+4,     0, 1, 0)); // r9 stray npc
    vt.push_back(V(1, 0, 1, 32'hDEADBEEF, 1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        RP+4,     0, 1, 0)); // r10 bus error
    for (int unsigned k = 0; k < 5; k++)
      vt.push_back(V(1, 0, 0, 32'h0, 0, 0, (k == 1), 32'h4000_0000, 0, 0, 1, 32'h0, RP+4, 1, 1, 1)); // r11-15 HOLD stalled
    vt.push_back(V(1, 0, 0, 32'h0,        0, 1, 1, 32'h9999_9990,0, 0, 1, 32'h0,        RP+4,     1, 1, 1)); // r16 handshake + stray npc
    vt.push_back(V(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        RP+4,     0, 2, 0)); // r17 WAIT_NPC
    vt.push_back(V(1, 0, 0, 32'h0,        0, 0, 1, RP+2,         0, 0, 0, 32'h0,        RP+4,     0, 2, 0)); // r18 misaligned redirect
    vt.push_back(V(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        RP+2,     0, 2, 0)); // r19 REQ, no request
    vt.push_back(V(1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 1, 32'h0,        RP+2,     1, 2, 1)); // r20 HOLD fault
    vt.push_back(V(1, 0, 0, 32'h0,        0, 0, 1, RP+8,         0, 0, 0, 32'h0,        RP+2,     0, 3, 0)); // r21
    vt.push_back(V(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        RP+8,     0, 3, 0)); // r22
    vt.push_back(V(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        RP+8,     0, 3, 0)); // r23 reset in WAIT_RSP
    vt.push_back(V(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        RP,       0, 0, 1)); // r24 restart
    vt.push_back(V(1, 0, 1, 32'h13,       0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        RP,       0, 0, 0)); // r25
    vt.push_back(V(1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 1, 32'h13,       RP,       0, 0, 1)); // r26
    vt.push_back(V(1, 0, 0, 32'h0,        0, 0, 1, RP+16,        0, 0, 0, 32'h0,        RP,       0, 1, 0)); // r27
    vt.push_back(V(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        RP+16,    0, 1, 0)); // r28
    vt.push_back(V(1, 0, 1, 32'h0010_0093,0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        RP+16,    0, 1, 0)); // r29
    vt.push_back(V(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 32'h0010_0093,RP+16,    0, 1, 1)); // r30 reset in HOLD
    vt.push_back(V(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        RP,       0, 0, 1)); // r31
    vt.push_back(V(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        RP,       0, 0, 1)); // r32

    rst = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    out_ready = 1'b0; npc_valid = 1'b0; npc = '0;
    @(negedge clk);
    @(negedge clk);

    // ---------------- table-driven phase ----------------
    for (int i = 0; i < vt.size(); i++) begin
      if (i != 0) @(negedge clk);
      rst = vt[i].rst; req_ready = vt[i].rqr; rsp_valid = vt[i].rsv;
      rsp_data = vt[i].rsd; rsp_err = vt[i].rse; out_ready = vt[i].ordy;
      npc_valid = vt[i].nv; npc = vt[i].n;
      #1;
      chk($sformatf("r%0d req_valid", i), {31'b0, req_valid}, {31'b0, vt[i].erqv});
      chk($sformatf("r%0d req_addr", i), req_addr, vt[i].epc);
      chk($sformatf("r%0d rsp_ready", i), {31'b0, rsp_ready}, {31'b0, vt[i].ersr});
      chk($sformatf("r%0d out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].eov});
      chk($sformatf("r%0d out_pc", i), out_pc, vt[i].epc);
      chk($sformatf("r%0d fetch_cnt", i), fetch_cnt, vt[i].ecnt);
      if (vt[i].co) begin
        chk($sformatf("r%0d out_inst", i), out_inst, vt[i].einst);
        chk($sformatf("r%0d out_fault", i), {31'b0, out_fault}, {31'b0, vt[i].eflt});
      end
    end

    // ---------------- randomized phase ----------------
    @(negedge clk);
    rst = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0; npc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_pc = RP; m_cnt = '0; m_req_done = 1'b0; mem_busy = 1'b0; mem_wait = 0;
    mem_addr = '0; mem_err = 1'b0; cur_err = 1'b0; npc_pending = 1'b0;
    npc_wait = 0; npc_nxt = '0; idle = 0; n_insts = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      req_ready = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
      rsp_err   = $urandom_range(0, 1) == 1;
      if (mem_busy && mem_wait == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = memf(mem_addr);
        rsp_err   = mem_err;
      end
      npc_drive = 1'b0;
      npc_valid = 1'b0;
      npc       = $urandom;
      if (npc_pending) begin
        if (npc_wait == 0) begin
          npc_valid = 1'b1;
          npc       = npc_nxt;
          npc_drive = 1'b1;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        npc_valid = 1'b1;   // stray pulse before commit has anything to say
      end
      #1;

      chk("rnd fetch_cnt", fetch_cnt, m_cnt);
      chk("rnd out_pc", out_pc, m_pc);

      if (rsp_valid) begin
        if (rsp_ready) mem_busy = 1'b0;
      end else if (mem_busy && mem_wait > 0) begin
        mem_wait--;
      end

      if (req_valid) begin
        chk("rnd req_legal", {31'b0, (m_pc[1:0] == 2'b00) && !m_req_done}, 32'd1);
        chk("rnd req_addr", req_addr, m_pc);
        if (req_ready) begin
          m_req_done = 1'b1;
          mem_busy   = 1'b1;
          mem_wait   = $urandom_range(0, 3);
          mem_addr   = req_addr;
          mem_err    = ($urandom_range(0, 5) == 0);
          cur_err    = mem_err;
        end
      end

      if (out_valid && out_ready) begin
        if (m_pc[1:0] != 2'b00) begin
          e_flt = 1'b1; e_inst = '0;
        end else begin
          e_flt = cur_err; e_inst = cur_err ? 32'h0 : memf(m_pc);
        end
        chk("rnd out_fault", {31'b0, out_fault}, {31'b0, e_flt});
        chk("rnd out_inst", out_inst, e_inst);
        chk("rnd one_request", {31'b0, m_req_done}, {31'b0, m_pc[1:0] == 2'b00});
        m_cnt++;
        n_insts++;
        idle        = 0;
        npc_pending = 1'b1;
        npc_wait    = $urandom_range(0, 3);
        npc_nxt     = RP + ($urandom_range(0, 255) << 2);
        if ($urandom_range(0, 5) == 0) npc_nxt = npc_nxt + $urandom_range(1, 3);
      end else begin
        idle++;
      end

      if (npc_drive) begin
        m_pc        = npc_nxt;
        m_req_done  = 1'b0;
        npc_pending = 1'b0;
      end else if (npc_pending && npc_wait > 0) begin
        npc_wait--;
      end

      if (idle > 80) begin
        total++;
        bad++;
        $display("FAIL rnd timeout: no instruction delivered for %0d cycles", idle);
        break;
      end
    end
    chk("rnd progress", {31'b0, n_insts >= 100}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
